mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs i_opcode [5:0] (IR[31:26]) and i_funct [5:0] (IR[5:0]), sampled in DECODE and all later states.
REQ-004 SHALL have input i_zf, 1 bit: ALU zero flag, used combinationally in BRANCH.
REQ-005 SHALL have input i_mem_ready, 1 bit: the memory access completes in any cycle where it is 1.
REQ-006 SHALL have output o_alu_control [3:0], with codes ADD=0000, SUB=0010, AND=0100, OR=0101, NOR=0110, SLT=1010.
REQ-007 SHALL have outputs o_alu_src_a (1 bit: 0=PC, 1=A), o_alu_src_b [1:0] (00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2) and o_pc_src [1:0] (00=ALU result, 01=ALUOut, 10=jump target).
REQ-008 SHALL have 1-bit outputs o_pc_en, o_iord, o_mem_read, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg, o_reg_write and o_illegal.

Function
REQ-009 SHALL be a Moore FSM with 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-010 FETCH SHALL drive: mem_read=1, iord=0, src_a=0, src_b=01, ALU ADD, pc_src=00. ir_write and pc_en SHALL be 1 only when i_mem_ready=1. The FSM SHALL stay in FETCH while i_mem_ready=0 and move to DECODE on ready.
REQ-011 DECODE SHALL drive src_a=0, src_b=11, ALU ADD (branch target into ALUOut).
REQ-012 DECODE SHALL go to MEMADR on lw (100011) or sw (101011), RTEXEC on 000000, BRANCH on beq (000100), ADDIEX on addi (001000) and JUMP on j (000010).
REQ-013 For any other opcode in DECODE, o_illegal SHALL pulse for one cycle and the FSM SHALL go to FETCH.
REQ-014 MEMADR SHALL drive src_a=1, src_b=10, ALU ADD, then go to MEMRD on lw or MEMWR on sw.
REQ-015 MEMRD SHALL drive iord=1 and mem_read=1, SHALL wait for i_mem_ready, then go to MEMWB.
REQ-016 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-017 MEMWR SHALL drive iord=1 and mem_write=1 held until i_mem_ready, then go to FETCH.
REQ-018 RTEXEC SHALL drive src_a=1, src_b=00, with ALU code from the funct decode: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 100111->NOR, 101010->SLT.
REQ-019 An unlisted funct in RTEXEC SHALL pulse o_illegal and go to FETCH, with no register write.
REQ-020 RTWB SHALL hold the RTEXEC ALU code and drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-021 BRANCH SHALL drive src_a=1, src_b=00, ALU SUB, pc_src=01, with o_pc_en=i_zf in the same cycle, then go to FETCH.
REQ-022 ADDIEX SHALL drive src_a=1, src_b=10, ALU ADD. ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-023 JUMP SHALL drive pc_src=10 and pc_en=1, then go to FETCH.
REQ-024 Any output not listed for a state SHALL be 0, with o_alu_control=ADD.
REQ-025 Instruction latencies SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, each plus any memory wait cycles.
REQ-026 mem_read and mem_write SHALL never both be 1.

Reset
REQ-027 i_rst=1 SHALL force the state to FETCH immediately, without waiting for a clock edge.
REQ-028 While i_rst=1, o_pc_en, o_ir_write, o_mem_read, o_mem_write, o_reg_write and o_illegal SHALL be 0, and all other outputs SHALL hold their FETCH values.
REQ-029 A reset during any state, including memory wait, SHALL abandon the instruction. The first cycle after reset release SHALL be a FETCH.

Structure
REQ-030 Package mc_pkg SHALL hold the state encoding (4 bits), the opcode and funct constants, the ALU control codes and the src/pc_src selector encodings.
REQ-031 Sub-module alu_decoder (combinational funct -> ALU code plus a valid flag) SHALL be instantiated once.

Verification
REQ-032 Reset mid-MEMRD with i_mem_ready=0: expect state FETCH asynchronously and mem_read=0 during reset. After release, FETCH with mem_read=1.
REQ-033 lw with i_mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD: expect exactly one ir_write pulse, one reg_write with mem_to_reg=1, and 10 cycles in total.
REQ-034 R-type funct 101010: expect o_alu_control=1010 in RTEXEC and RTWB, reg_dst=1 and one reg_write.
REQ-035 R-type funct 000000: expect an o_illegal pulse, no reg_write, and a return to FETCH.
REQ-036 beq with i_zf=1: expect pc_en=1 with pc_src=01 in BRANCH. With i_zf=0: expect pc_en=0. Both take 3 cycles.
REQ-037 Opcode 111111: expect an o_illegal pulse in DECODE and the next state FETCH. Then j: expect pc_en=1 with pc_src=10.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, instruction opcode/funct constants, ALU control codes and the
// datapath selector encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  // ALU operand A select
  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// Signal bundle between the control unit and the datapath/memory side.
// master: the datapath side (supplies instruction fields and status,
//         consumes control strobes).
// slave:  the control unit.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zf;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  modport master (
    output opcode, funct, zf, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal
  );

  modport slave (
    input  opcode, funct, zf, mem_ready,
    output alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder.
// Ports: funct    - IR[5:0]
//        alu_code - ALU control code (ADD when funct is not recognised)
//        valid    - 1 when funct is a supported R-type operation
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       valid
);

  always_comb begin
    alu_code = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_NOR:  alu_code = ALU_NOR;
      FN_SLT:  alu_code = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit (Moore FSM, 12 states).
// Ports: i_clk/i_rst            - clock, asynchronous active-high reset
//        i_opcode/i_funct       - instruction fields, used from DECODE on
//        i_zf                   - ALU zero flag (BRANCH)
//        i_mem_ready            - memory access completes this cycle
//        o_alu_control          - ALU operation code
//        o_alu_src_a/b, o_pc_src- datapath selectors
//        o_pc_en .. o_reg_write - datapath strobes
//        o_illegal              - one-cycle pulse on unsupported opcode/funct
module mc_control
  import mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zf,
  input  logic       i_mem_ready,
  output logic [3:0] o_alu_control,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_pc_src,
  output logic       o_pc_en,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_illegal
);

  state_t     state, next_state;
  logic [3:0] dec_code;
  logic       dec_valid;
  logic [3:0] alu_hold;

  logic pc_en, mem_read, mem_write, ir_write, reg_write, illegal;

  alu_decoder u_alu_decoder (
    .funct    (i_funct),
    .alu_code (dec_code),
    .valid    (dec_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_FETCH;
    else       state <= next_state;
  end

  // RTWB replays the operation chosen in RTEXEC.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  alu_hold <= ALU_ADD;
    else if (state == S_RTEXEC) alu_hold <= dec_code;
  end

  always_comb begin
    next_state    = state;
    o_alu_control = ALU_ADD;
    o_alu_src_a   = SRC_A_PC;
    o_alu_src_b   = SRC_B_REG;
    o_pc_src      = PC_SRC_ALU;
    o_iord        = 1'b0;
    o_reg_dst     = 1'b0;
    o_mem_to_reg  = 1'b0;
    pc_en         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        o_alu_src_b = SRC_B_FOUR;
        if (i_mem_ready) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_b = SRC_B_IMM_SH2;
        case (i_opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTEXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = SRC_A_REG;
        o_alu_src_b = SRC_B_IMM;
        next_state  = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_iord   = 1'b1;
        mem_read = 1'b1;
        if (i_mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        o_mem_to_reg = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEMWR: begin
        o_iord    = 1'b1;
        mem_write = 1'b1;
        if (i_mem_ready) next_state = S_FETCH;
      end
      S_RTEXEC: begin
        o_alu_src_a   = SRC_A_REG;
        o_alu_control = dec_code;
        if (dec_valid) begin
          next_state = S_RTWB;
        end else begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_RTWB: begin
        o_alu_control = alu_hold;
        reg_write     = 1'b1;
        o_reg_dst     = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a   = SRC_A_REG;
        o_alu_control = ALU_SUB;
        o_pc_src      = PC_SRC_ALUOUT;
        pc_en         = i_zf;
        next_state    = S_FETCH;
      end
      S_ADDIEX: begin
        o_alu_src_a = SRC_A_REG;
        o_alu_src_b = SRC_B_IMM;
        next_state  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        o_pc_src   = PC_SRC_JUMP;
        pc_en      = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // State is already FETCH while reset is held, so selectors show FETCH
  // values; only the side-effecting strobes need masking.
  assign o_pc_en     = pc_en     & ~i_rst;
  assign o_mem_read  = mem_read  & ~i_rst;
  assign o_mem_write = mem_write & ~i_rst;
  assign o_ir_write  = ir_write  & ~i_rst;
  assign o_reg_write = reg_write & ~i_rst;
  assign o_illegal   = illegal   & ~i_rst;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a table of instructions is expanded by
// an independent phase model into per-cycle expected outputs, queued when
// stimulus is driven and compared half a cycle later; a hand-written sequence
// covers asynchronous reset in the middle of a memory wait.
module tb_mc_control;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_opcode      (bus.opcode),
    .i_funct       (bus.funct),
    .i_zf          (bus.zf),
    .i_mem_ready   (bus.mem_ready),
    .o_alu_control (bus.alu_control),
    .o_alu_src_a   (bus.alu_src_a),
    .o_alu_src_b   (bus.alu_src_b),
    .o_pc_src      (bus.pc_src),
    .o_pc_en       (bus.pc_en),
    .o_iord        (bus.iord),
    .o_mem_read    (bus.mem_read),
    .o_mem_write   (bus.mem_write),
    .o_ir_write    (bus.ir_write),
    .o_reg_dst     (bus.reg_dst),
    .o_mem_to_reg  (bus.mem_to_reg),
    .o_reg_write   (bus.reg_write),
    .o_illegal     (bus.illegal)
  );

  typedef enum logic [3:0] {
    P_F, P_D, P_MA, P_MR, P_MWB, P_MWR, P_RX, P_RWB, P_BR, P_AX, P_AWB, P_J
  } phase_t;

  typedef struct {
    phase_t p;
    logic   rdy;
    logic   care;
  } step_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zf;
    int unsigned fwait;
    int unsigned mwait;
    int unsigned n_rw;
    int unsigned n_ill;
    int unsigned n_pc;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];
  step_t       steps[$];
  int unsigned cnt_irw, cnt_rw, cnt_ill, cnt_pc;

  // Packed output word: {alu[3:0], src_a, src_b[1:0], pc_src[1:0],
  //                      pc_en, iord, mem_read, mem_write, ir_write,
  //                      reg_dst, mem_to_reg, reg_write, illegal}
  function automatic logic [17:0] pk(input logic [3:0] alu, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [8:0] flags);
    return {alu, sa, sb, ps, flags};
  endfunction

  function automatic logic [4:0] ref_fn(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0000;
      6'b100010: return 5'b1_0010;
      6'b100100: return 5'b1_0100;
      6'b100101: return 5'b1_0101;
      6'b100111: return 5'b1_0110;
      6'b101010: return 5'b1_1010;
      default:   return 5'b0_0000;
    endcase
  endfunction

  function automatic logic op_bad(input logic [5:0] op);
    return !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
  endfunction

  function automatic logic [17:0] ref_out(input phase_t p, input logic rdy,
                                          input logic zf, input logic [5:0] op,
                                          input logic [5:0] fn);
    logic [4:0] d;
    d = ref_fn(fn);
    case (p)
      P_F:   return pk(4'b0000, 1'b0, 2'b01, 2'b00, {rdy, 1'b0, 1'b1, 1'b0, rdy, 4'b0000});
      P_D:   return pk(4'b0000, 1'b0, 2'b11, 2'b00, {8'b0, op_bad(op)});
      P_MA:  return pk(4'b0000, 1'b1, 2'b10, 2'b00, 9'b000000000);
      P_MR:  return pk(4'b0000, 1'b0, 2'b00, 2'b00, 9'b011000000);
      P_MWB: return pk(4'b0000, 1'b0, 2'b00, 2'b00, 9'b000000110);
      P_MWR: return pk(4'b0000, 1'b0, 2'b00, 2'b00, 9'b010100000);
      P_RX:  return pk(d[3:0],  1'b1, 2'b00, 2'b00, {8'b0, ~d[4]});
      P_RWB: return pk(d[3:0],  1'b0, 2'b00, 2'b00, 9'b000001010);
      P_BR:  return pk(4'b0010, 1'b1, 2'b00, 2'b01, {zf, 8'b0});
      P_AX:  return pk(4'b0000, 1'b1, 2'b10, 2'b00, 9'b000000000);
      P_AWB: return pk(4'b0000, 1'b0, 2'b00, 2'b00, 9'b000000010);
      P_J:   return pk(4'b0000, 1'b0, 2'b00, 2'b10, 9'b100000000);
      default: return '0;
    endcase
  endfunction

  function automatic logic [17:0] act_out();
    return pk(bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
              {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
               bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal});
  endfunction

  task automatic check(input string nm, input logic [17:0] exp);
    logic [17:0] act;
    act = act_out();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: outputs got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_cnt(input string nm, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: count got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_step(input phase_t p, input logic rdy, input logic care);
    step_t s;
    s.p = p; s.rdy = rdy; s.care = care;
    steps.push_back(s);
  endtask

  task automatic push_wait(input phase_t p, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) push_step(p, 1'b0, 1'b1);
    push_step(p, 1'b1, 1'b1);
  endtask

  task automatic build(input vec_t v);
    steps.delete();
    push_wait(P_F, v.fwait);
    push_step(P_D, 1'b0, 1'b0);
    case (v.op)
      6'b100011: begin
        push_step(P_MA, 1'b0, 1'b0);
        push_wait(P_MR, v.mwait);
        push_step(P_MWB, 1'b0, 1'b0);
      end
      6'b101011: begin
        push_step(P_MA, 1'b0, 1'b0);
        push_wait(P_MWR, v.mwait);
      end
      6'b000000: begin
        push_step(P_RX, 1'b0, 1'b0);
        if (ref_fn(v.fn) >= 5'b1_0000) push_step(P_RWB, 1'b0, 1'b0);
      end
      6'b000100: push_step(P_BR, 1'b0, 1'b0);
      6'b001000: begin
        push_step(P_AX, 1'b0, 1'b0);
        push_step(P_AWB, 1'b0, 1'b0);
      end
      6'b000010: push_step(P_J, 1'b0, 1'b0);
      default: ;
    endcase
  endtask

  // One clock cycle: drive just after the rising edge, compare at the
  // falling edge. Inputs the current phase must ignore are randomised.
  task automatic apply(input step_t s, input vec_t v, input string nm);
    logic r, z;
    @(posedge clk);
    #1;
    r = s.care ? s.rdy : 1'($urandom_range(0, 1));
    z = (s.p == P_BR) ? v.zf : 1'($urandom_range(0, 1));
    bus.mem_ready = r;
    bus.zf        = z;
    if (s.p == P_F) begin
      bus.opcode = 6'($urandom);
      bus.funct  = 6'($urandom);
    end else begin
      bus.opcode = v.op;
      bus.funct  = v.fn;
    end
    exp_q.push_back(ref_out(s.p, r, z, v.op, v.fn));
    @(negedge clk);
    check(nm, exp_q.pop_front());
    cnt_irw += int'(bus.ir_write);
    cnt_rw  += int'(bus.reg_write);
    cnt_ill += int'(bus.illegal);
    cnt_pc  += int'(bus.pc_en);
  endtask

  vec_t tbl[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  v;
    step_t s;

    tbl[0]  = '{"lw_wait",  6'b100011, 6'b010101, 1'b0, 2, 3, 1, 0, 1};
    tbl[1]  = '{"sw",       6'b101011, 6'b000111, 1'b0, 0, 1, 0, 0, 1};
    tbl[2]  = '{"r_add",    6'b000000, 6'b100000, 1'b0, 0, 0, 1, 0, 1};
    tbl[3]  = '{"r_sub",    6'b000000, 6'b100010, 1'b0, 1, 0, 1, 0, 1};
    tbl[4]  = '{"r_and",    6'b000000, 6'b100100, 1'b0, 0, 0, 1, 0, 1};
    tbl[5]  = '{"r_or",     6'b000000, 6'b100101, 1'b0, 0, 0, 1, 0, 1};
    tbl[6]  = '{"r_nor",    6'b000000, 6'b100111, 1'b0, 0, 0, 1, 0, 1};
    tbl[7]  = '{"r_slt",    6'b000000, 6'b101010, 1'b0, 0, 0, 1, 0, 1};
    tbl[8]  = '{"r_bad",    6'b000000, 6'b000000, 1'b0, 0, 0, 0, 1, 1};
    tbl[9]  = '{"beq_t",    6'b000100, 6'b110011, 1'b1, 0, 0, 0, 0, 2};
    tbl[10] = '{"beq_f",    6'b000100, 6'b110011, 1'b0, 0, 0, 0, 0, 1};
    tbl[11] = '{"addi",     6'b001000, 6'b000001, 1'b0, 0, 0, 1, 0, 1};
    tbl[12] = '{"op_bad",   6'b111111, 6'b100000, 1'b0, 0, 0, 0, 1, 1};
    tbl[13] = '{"j",        6'b000010, 6'b001100, 1'b0, 0, 0, 0, 0, 2};
    tbl[14] = '{"lw_fast",  6'b100011, 6'b000000, 1'b0, 0, 0, 1, 0, 1};

    // Hold reset with mem_ready high: FETCH selectors, strobes masked.
    bus.opcode = '0; bus.funct = '0; bus.zf = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", pk(4'b0000, 1'b0, 2'b01, 2'b00, 9'b0));

    // Release with mem_ready low: a stalled FETCH.
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    exp_q.push_back(ref_out(P_F, 1'b0, 1'b0, 6'b0, 6'b0));
    @(negedge clk);
    check("reset_release", exp_q.pop_front());

    for (int unsigned i = 0; i < 15; i++) begin
      v = tbl[i];
      build(v);
      cnt_irw = 0; cnt_rw = 0; cnt_ill = 0; cnt_pc = 0;
      foreach (steps[k]) apply(steps[k], v, $sformatf("%s_c%0d", v.name, k));
      check_cnt({v.name, "_ir_write"}, cnt_irw, 1);
      check_cnt({v.name, "_reg_write"}, cnt_rw, v.n_rw);
      check_cnt({v.name, "_illegal"}, cnt_ill, v.n_ill);
      check_cnt({v.name, "_pc_en"}, cnt_pc, v.n_pc);
    end

    // The last instruction must have returned to FETCH.
    s.p = P_F; s.rdy = 1'b0; s.care = 1'b1;
    apply(s, tbl[0], "final_fetch");

    // Reset in the middle of a MEMRD wait.
    v = tbl[14];
    s.p = P_F;  s.rdy = 1'b1; s.care = 1'b1; apply(s, v, "mr_rst_fetch");
    s.p = P_D;  s.care = 1'b0;               apply(s, v, "mr_rst_decode");
    s.p = P_MA;                              apply(s, v, "mr_rst_memadr");
    s.p = P_MR; s.rdy = 1'b0; s.care = 1'b1; apply(s, v, "mr_rst_wait0");
    apply(s, v, "mr_rst_wait1");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", pk(4'b0000, 1'b0, 2'b01, 2'b00, 9'b0));
    @(negedge clk);
    check("rst_held", pk(4'b0000, 1'b0, 2'b01, 2'b00, 9'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    exp_q.push_back(ref_out(P_F, 1'b0, 1'b0, 6'b0, 6'b0));
    @(negedge clk);
    check("rst_mid_release", exp_q.pop_front());

    // A complete instruction after the abandoned one.
    v = tbl[13];
    build(v);
    foreach (steps[k]) apply(steps[k], v, $sformatf("post_rst_j_c%0d", k));
    s.p = P_F; s.rdy = 1'b0; s.care = 1'b1;
    apply(s, v, "post_rst_fetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
